// File: rtl/simon_says_multi.sv
// N-player Simon Says round engine: LFSR target, show window, response window, one-cycle judge.
// Optional SIMON_PENALTY_EN: wrong answers decrement the score, saturating at zero.
module simon_says_multi #(
    parameter int          NUM_PLAYERS = 2,
    parameter int          DIR_W       = 2,
    parameter int          SCORE_W     = 3,
    parameter int          WIN_SCORE   = 7,
    parameter int          SHOW_CYC    = 50_000_000,
    parameter int          WAIT_CYC    = 100_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_PLAYERS-1:0]         p_valid,
    input  logic [NUM_PLAYERS*DIR_W-1:0]   p_dir,
    output logic [DIR_W-1:0]               target_dir,
    output logic [DIR_W-1:0]               led_dir,
    output logic                           led_on,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [7:0]                     round_cnt,
    output logic                           game_over,
    output logic [NUM_PLAYERS-1:0]         winner,
    output logic                           busy
);
    localparam int MAX_CYC = (SHOW_CYC > WAIT_CYC) ? SHOW_CYC : WAIT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {IDLE, SHOW, WAIT, JUDGE, DONE} state_t;

    state_t                                  state;
    logic [15:0]                             lfsr;
    logic [15:0]                             lfsr_nxt;
    logic [CNT_W-1:0]                        cnt;
    logic [NUM_PLAYERS-1:0]                  answered;
    logic [NUM_PLAYERS-1:0][DIR_W-1:0]       ans;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]     score_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]     score_nxt;
    logic [NUM_PLAYERS-1:0]                  win_nxt;

    // Fibonacci x^16+x^14+x^13+x^11+1, feedback enters at bit 0.
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign scores   = score_q;

    always_comb begin
        score_nxt = score_q;
        win_nxt   = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (answered[i] && ans[i] == target_dir) begin
                if (score_q[i] != WIN) score_nxt[i] = score_q[i] + 1'b1;
            end
`ifdef SIMON_PENALTY_EN
            else if (answered[i] && score_q[i] != '0) begin
                score_nxt[i] = score_q[i] - 1'b1;
            end
`endif
            win_nxt[i] = (score_nxt[i] == WIN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            cnt        <= '0;
            answered   <= '0;
            ans        <= '0;
            score_q    <= '0;
            target_dir <= '0;
            led_dir    <= '0;
            led_on     <= 1'b0;
            round_cnt  <= '0;
            game_over  <= 1'b0;
            winner     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SHOW;
                        lfsr       <= lfsr_nxt;
                        target_dir <= lfsr_nxt[DIR_W-1:0];
                        led_dir    <= lfsr_nxt[DIR_W-1:0];
                        led_on     <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        score_q    <= '0;
                        round_cnt  <= '0;
                        winner     <= '0;
                        game_over  <= 1'b0;
                        answered   <= '0;
                        ans        <= '0;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state   <= WAIT;
                        cnt     <= '0;
                        led_on  <= 1'b0;
                        led_dir <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // Only a player's first strobe in the window counts.
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (p_valid[i] && !answered[i]) begin
                            answered[i] <= 1'b1;
                            ans[i]      <= p_dir[i*DIR_W +: DIR_W];
                        end
                    end
                    if (cnt == WAIT_LAST) begin
                        state <= JUDGE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                JUDGE: begin
                    score_q  <= score_nxt;
                    answered <= '0;
                    ans      <= '0;
                    if (round_cnt != 8'hFF) round_cnt <= round_cnt + 1'b1;
                    if (|win_nxt) begin
                        state     <= DONE;
                        winner    <= win_nxt;
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state      <= SHOW;
                        lfsr       <= lfsr_nxt;
                        target_dir <= lfsr_nxt[DIR_W-1:0];
                        led_dir    <= lfsr_nxt[DIR_W-1:0];
                        led_on     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/simon_says_multi.md
Name: simon_says_multi

Overview:
- N-player, round-based Simon Says engine.
- Each round: advance a 16-bit LFSR, show a DIR_W-bit target direction on the LEDs for a fixed window, collect each player's first answer during a response window, then score all players in one cycle.
- Game ends when any player reaches WIN_SCORE.
- Sits between debounced player input pads and the LED/7-seg display logic; replaces the fixed 2-player, 1 s, free-running scorer.

Parameters:
- NUM_PLAYERS, 2, number of players (1..8).
- DIR_W, 2, direction width in bits (1..8).
- SCORE_W, 3, per-player score width.
- WIN_SCORE, 7, score that ends the game (must be <= 2^SCORE_W-1).
- SHOW_CYC, 50_000_000, cycles the target is displayed.
- WAIT_CYC, 100_000_000, cycles of the response window.
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new game from IDLE or DONE
- p_valid  in  NUM_PLAYERS  per-player answer strobe
- p_dir  in  NUM_PLAYERS*DIR_W  packed answers; player i at [i*DIR_W +: DIR_W]
- target_dir  out  DIR_W  current round's target
- led_dir  out  DIR_W  target while led_on=1, else 0
- led_on  out  1  high during SHOW
- scores  out  NUM_PLAYERS*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W]
- round_cnt  out  8  completed rounds, saturates at 255
- game_over  out  1  high in DONE
- winner  out  NUM_PLAYERS  one-hot or multi-hot set of winners
- busy  out  1  high in SHOW, WAIT or JUDGE

Behaviour:
- Reset state: FSM=IDLE, lfsr=LFSR_SEED; all outputs 0.
- LFSR:
  - Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shifts exactly once per round, on the IDLE/DONE/JUDGE -> SHOW transition.
  - target_dir is registered as the post-shift lfsr[DIR_W-1:0] in that same cycle.
- IDLE:
  - start=1 -> SHOW.
  - On this transition, clear scores, round_cnt, winner and the answer latches.
- SHOW:
  - led_on=1, led_dir=target_dir.
  - Cycle counter runs 0..SHOW_CYC-1, then -> WAIT.
  - p_valid is ignored in SHOW (early answers are discarded).
- WAIT:
  - Counter runs 0..WAIT_CYC-1, then -> JUDGE.
  - Per player: the first cycle with p_valid[i]=1 sets answered[i] and latches p_dir slice into ans[i].
  - Later strobes from that player are ignored until the next round.
  - Simultaneous strobes from different players are all accepted.
- JUDGE (exactly 1 cycle):
  - For each i with answered[i] && ans[i]==target_dir: score[i] <= score[i]+1, saturating at WIN_SCORE.
  - Unanswered players: unchanged.
  - round_cnt += 1, saturating at 255.
  - Answer latches cleared.
  - If any updated score == WIN_SCORE: winner[i]=1 for every such i (ties give multi-hot), game_over=1, -> DONE.
  - Else -> SHOW.
- DONE:
  - game_over, winner and scores hold.
  - start=1 clears them and goes -> SHOW. This is one cycle of IDLE-equivalent clearing merged into the transition.
  - The LFSR is NOT reseeded, so the next game gets a new sequence.
- start outside IDLE/DONE is ignored.
- rst asserted in any state, including mid-window: immediate return to the reset state. The LFSR returns to LFSR_SEED.
- Counters are sized $clog2(max(SHOW_CYC,WAIT_CYC))+1.

Optional Feature:
- Macro: SIMON_PENALTY_EN
- Defined:
  - In JUDGE, a player who answered with a wrong direction has score decremented, saturating at 0.
  - Correct and unanswered behaviour is unchanged.
- Undefined:
  - Wrong answers leave the score unchanged (no penalty logic synthesised).

Test Plan (SHOW_CYC=4, WAIT_CYC=8, NUM_PLAYERS=2, DIR_W=2, WIN_SCORE=3):
- Reset, then start pulse:
  - led_on=1 for exactly 4 cycles.
  - target_dir equals lfsr[1:0] after one shift of 16'hACE1.
  - scores=0, busy=1.
- P0 answers correct, P1 answers wrong, then P1 answers correct in the same WAIT:
  - After JUDGE: P0=1, P1=0 (P1's second strobe ignored).
  - round_cnt=1.
- Answers during SHOW only, none in WAIT:
  - Scores unchanged after JUDGE.
  - round_cnt increments.
- Both players answer correctly every round:
  - After round 3, winner=2'b11, game_over=1.
  - Outputs hold for 20 idle cycles.
  - start then clears scores and gives a different first target.
- rst asserted mid-WAIT with P0 already answered:
  - All outputs 0, FSM IDLE.
  - The next start reproduces the first target from the seed.
- With SIMON_PENALTY_EN defined:
  - P0 at score 1 answers wrong -> score 0.
  - Answers wrong again -> stays 0.
  - P1 not answering is unchanged.
